// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath width and the divide-sequencer state encoding.
package cpu_defs;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, record the compare bit.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtraction; a clear top bit of the difference means the divisor fit.
  always_comb begin
    shifted = {rem, q[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// EX-stage DIV/DIVU sequencer: stalls the pipeline while a WIDTH-step
// restoring divide runs on operand magnitudes, then presents the sign-fixed
// quotient (lo_o) and remainder (hi_o) with a one-cycle valid.
module div_sequencer
  import cpu_defs::*;
#(
  parameter int unsigned WIDTH = cpu_defs::WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  input  logic             stall_ext,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             a_neg;
  logic             b_neg;

  assign a_neg = signed_div & opa[WIDTH-1];
  assign b_neg = signed_div & opb[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .q        (quo_q),
    .divisor  (dsr_q),
    .rem_next (rem_step),
    .q_next   (quo_step)
  );

  // State and datapath registers; reset wins over everything including flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      count_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      count_q <= count_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  // Next-state, datapath update, stall request and result valid.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    count_d = count_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    stall_o = 1'b0;
    valid_o = 1'b0;

    case (state_q)
      DIV_IDLE: begin
        if (start && !flush) begin
          stall_o = 1'b1;
          if (opb != '0) begin
            state_d = DIV_BUSY;
            rem_d   = '0;
            quo_d   = a_neg ? -opa : opa;
            dsr_d   = b_neg ? -opb : opb;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            count_d = '0;
          end else begin
            // Divide by zero is a defined result, not a trap.
            state_d = DIV_DONE;
            lo_d    = '1;
            hi_d    = opa;
          end
        end
      end

      DIV_BUSY: begin
        stall_o = 1'b1;
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d   = rem_step;
          quo_d   = quo_step;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(WIDTH - 1)) begin
            state_d = DIV_DONE;
            count_d = '0;
            lo_d    = negq_q ? -quo_step : quo_step;
            hi_d    = negr_q ? -rem_step : rem_step;
          end
        end
      end

      DIV_DONE: begin
        valid_o = !flush;
        if (flush || !stall_ext) begin
          state_d = DIV_IDLE;
        end
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  assign lo_o = lo_q;
  assign hi_o = hi_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer.
module tb_div_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        flush;
  logic        stall_ext;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] lo_o;
  logic [31:0] hi_o;

  int passed;
  int total;

  div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opa        (opa),
    .opb        (opb),
    .flush      (flush),
    .stall_ext  (stall_ext),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .lo_o       (lo_o),
    .hi_o       (hi_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one divide and wait (bounded) for valid; start is left high.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sd,
                        output logic got, output int lat, output int stalls,
                        output logic [31:0] lo, output logic [31:0] hi, output logic stl);
    got = 1'b0; lat = 0; stalls = 0; lo = '0; hi = '0; stl = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; opa = a; opb = b; signed_div = sd;
    while (!got && lat < 60) begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        got = 1'b1; lo = lo_o; hi = hi_o; stl = stall_o;
      end else begin
        if (stall_o === 1'b1) stalls++;
        lat++;
        if (lat == 2) begin
          opa = ~a; opb = b + 32'd1; signed_div = ~sd;
        end
      end
    end
  endtask

  // Instruction leaves EX at the next edge.
  task automatic leave_ex();
    @(posedge clk); #1;
    start = 1'b0; stall_ext = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (stall_o !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_o); else passed++;
    total++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_o); else passed++;
    total++; if (lo_o !== 32'h0) $display("FAIL reset_lo got=%h exp=0", lo_o); else passed++;
    total++; if (hi_o !== 32'h0) $display("FAIL reset_hi got=%h exp=0", hi_o); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_divu();
    logic got, stl; int lat, st; logic [31:0] lo, hi;
    do_div(32'd100, 32'd7, 1'b0, got, lat, st, lo, hi, stl);
    total++; if (!got) $display("FAIL divu_timeout no valid within bound"); else passed++;
    total++; if (lat != 33) $display("FAIL divu_latency got=%0d exp=33", lat); else passed++;
    total++; if (st != 33) $display("FAIL divu_stall_cycles got=%0d exp=33", st); else passed++;
    total++; if (stl !== 1'b0) $display("FAIL divu_stall_in_done got=%b exp=0", stl); else passed++;
    total++; if (lo !== 32'd14) $display("FAIL divu_lo got=%h exp=%h", lo, 32'd14); else passed++;
    total++; if (hi !== 32'd2) $display("FAIL divu_hi got=%h exp=%h", hi, 32'd2); else passed++;
    leave_ex();
    @(negedge clk);
    total++; if ({stall_o, valid_o} !== 2'b00) $display("FAIL divu_idle_after got=%b exp=00", {stall_o, valid_o}); else passed++;
    do_div(32'hFFFF_FFFF, 32'h10, 1'b0, got, lat, st, lo, hi, stl);
    total++; if (lo !== 32'h0FFF_FFFF) $display("FAIL divu_big_lo got=%h exp=0fffffff", lo); else passed++;
    total++; if (hi !== 32'hF) $display("FAIL divu_big_hi got=%h exp=0000000f", hi); else passed++;
    leave_ex();
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, got, lat, st, lo, hi, stl);
    total++; if (lo !== 32'h7FFF_FFFC) $display("FAIL divu_neg_lo got=%h exp=7ffffffc", lo); else passed++;
    total++; if (hi !== 32'd1) $display("FAIL divu_neg_hi got=%h exp=00000001", hi); else passed++;
    leave_ex();
  endtask

  task automatic test_div_signed();
    logic got, stl; int lat, st; logic [31:0] lo, hi;
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, got, lat, st, lo, hi, stl);
    total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_m7_2_lo got=%h exp=fffffffd", lo); else passed++;
    total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_m7_2_hi got=%h exp=ffffffff", hi); else passed++;
    leave_ex();
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, got, lat, st, lo, hi, stl);
    total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_7_m2_lo got=%h exp=fffffffd", lo); else passed++;
    total++; if (hi !== 32'd1) $display("FAIL div_7_m2_hi got=%h exp=00000001", hi); else passed++;
    leave_ex();
  endtask

  task automatic test_overflow();
    logic got, stl; int lat, st; logic [31:0] lo, hi;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, got, lat, st, lo, hi, stl);
    total++; if (lo !== 32'h8000_0000) $display("FAIL ovf_lo got=%h exp=80000000", lo); else passed++;
    total++; if (hi !== 32'h0) $display("FAIL ovf_hi got=%h exp=00000000", hi); else passed++;
    leave_ex();
  endtask

  task automatic test_div_zero();
    logic got, stl; int lat, st; logic [31:0] lo, hi;
    do_div(32'd5, 32'd0, 1'b0, got, lat, st, lo, hi, stl);
    total++; if (!got) $display("FAIL dz_timeout no valid within bound"); else passed++;
    total++; if (lat != 1) $display("FAIL dz_latency got=%0d exp=1", lat); else passed++;
    total++; if (st != 1) $display("FAIL dz_stall_cycles got=%0d exp=1", st); else passed++;
    total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL dz_lo got=%h exp=ffffffff", lo); else passed++;
    total++; if (hi !== 32'd5) $display("FAIL dz_hi got=%h exp=00000005", hi); else passed++;
    leave_ex();
  endtask

  task automatic test_flush();
    logic got, stl; int lat, st; logic [31:0] lo, hi;
    int vseen;
    vseen = 0;
    @(posedge clk); #1;
    start = 1'b1; opa = 32'd100; opb = 32'd7; signed_div = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid_o === 1'b1) vseen++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    total++; if (stall_o !== 1'b1) $display("FAIL flush_busy_stall got=%b exp=1", stall_o); else passed++;
    total++; if (valid_o !== 1'b0) $display("FAIL flush_busy_valid got=%b exp=0", valid_o); else passed++;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    total++; if (stall_o !== 1'b0) $display("FAIL flush_idle_stall got=%b exp=0", stall_o); else passed++;
    total++; if (valid_o !== 1'b0) $display("FAIL flush_idle_valid got=%b exp=0", valid_o); else passed++;
    total++; if (vseen != 0) $display("FAIL flush_no_valid got=%0d exp=0", vseen); else passed++;
    do_div(32'd9, 32'd3, 1'b0, got, lat, st, lo, hi, stl);
    total++; if (lat != 33) $display("FAIL flush_restart_latency got=%0d exp=33", lat); else passed++;
    total++; if (lo !== 32'd3) $display("FAIL flush_restart_lo got=%h exp=00000003", lo); else passed++;
    total++; if (hi !== 32'd0) $display("FAIL flush_restart_hi got=%h exp=00000000", hi); else passed++;
    leave_ex();
  endtask

  task automatic test_stall_ext();
    logic got, stl; int lat, st; logic [31:0] lo, hi;
    do_div(32'd20, 32'd6, 1'b0, got, lat, st, lo, hi, stl);
    total++; if ({lo, hi} !== {32'd3, 32'd2}) $display("FAIL sx_first got=%h/%h exp=3/2", lo, hi); else passed++;
    stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({valid_o, stall_o, lo_o, hi_o} !== {1'b1, 1'b0, 32'd3, 32'd2})
        $display("FAIL sx_hold%0d got v=%b s=%b lo=%h hi=%h exp v=1 s=0 lo=3 hi=2", i, valid_o, stall_o, lo_o, hi_o);
      else passed++;
      if (i == 1) stall_ext = 1'b1;
    end
    stall_ext = 1'b0;
    leave_ex();
    @(negedge clk);
    total++; if (valid_o !== 1'b0) $display("FAIL sx_release_valid got=%b exp=0", valid_o); else passed++;
  endtask

  task automatic test_back_to_back();
    logic got, stl; int lat, st; logic [31:0] lo, hi;
    do_div(32'd100, 32'd7, 1'b0, got, lat, st, lo, hi, stl);
    total++; if ({lo, hi} !== {32'd14, 32'd2}) $display("FAIL b2b_first got=%h/%h exp=e/2", lo, hi); else passed++;
    do_div(32'd50, 32'd5, 1'b0, got, lat, st, lo, hi, stl);
    total++; if (lat != 33) $display("FAIL b2b_latency got=%0d exp=33", lat); else passed++;
    total++; if ({lo, hi} !== {32'd10, 32'd0}) $display("FAIL b2b_second got=%h/%h exp=a/0", lo, hi); else passed++;
    leave_ex();
  endtask

  task automatic test_reset_mid();
    int vseen;
    vseen = 0;
    @(posedge clk); #1;
    start = 1'b1; opa = 32'd100; opb = 32'd7; signed_div = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; flush = 1'b1; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (stall_o !== 1'b0) $display("FAIL rstmid_stall got=%b exp=0", stall_o); else passed++;
    total++; if (valid_o !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", valid_o); else passed++;
    total++; if (lo_o !== 32'h0) $display("FAIL rstmid_lo got=%h exp=0", lo_o); else passed++;
    total++; if (hi_o !== 32'h0) $display("FAIL rstmid_hi got=%h exp=0", hi_o); else passed++;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o === 1'b1) vseen++;
    end
    total++; if (vseen != 0) $display("FAIL rstmid_no_valid got=%0d exp=0", vseen); else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; opa = '0; opb = '0;
    flush = 1'b0; stall_ext = 1'b0;
    test_reset();
    test_divu();
    test_div_signed();
    test_overflow();
    test_div_zero();
    test_flush();
    test_stall_ext();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller and iterative datapath for MIPS DIV/DIVU in the EX stage.
- Accepts a divide request from the decoded instruction and stalls the pipeline while it runs.
- Produces quotient (LO) and remainder (HI) with a one-cycle valid that qualifies the hilowrite path.
- Owns the FSM, the iteration counter and the restoring shift/subtract datapath.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  EX-stage instruction is DIV/DIVU; held high until the instruction leaves EX
signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start in IDLE
opa  input  WIDTH  dividend (rs); sampled in IDLE when accepted
opb  input  WIDTH  divisor (rt); sampled in IDLE when accepted
flush  input  1  EX instruction cancelled (exception/branch flush); aborts any operation
stall_ext  input  1  pipeline held by another source; holds the DONE state
stall_o  output  1  request to freeze IF/ID/EX
valid_o  output  1  result valid; qualifies the HI/LO write
lo_o  output  WIDTH  quotient
hi_o  output  WIDTH  remainder

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, count=0, stall_o=0, valid_o=0, lo_o=0, hi_o=0, internal registers=0.
- States and transitions:
  - IDLE.
    - start & !flush & opb!=0 -> BUSY. Latch magnitudes |opa| and |opb|; |x| is taken only when signed_div=1. Latch neg_q = signed_div & (opa[MSB] ^ opb[MSB]) and neg_r = signed_div & opa[MSB]. Set count=0.
    - start & !flush & opb==0 -> DONE directly. Latch lo=all-ones and hi=opa; this result is decided, not a trap.
    - Otherwise remain in IDLE.
  - BUSY.
    - Each cycle performs one restoring step: rem = {rem, q[MSB]} - divisor if non-negative, else the shifted value is kept; the quotient shifts left, inserting the compare bit.
    - count increments each cycle; after WIDTH steps (count==WIDTH-1 on the final step) -> DONE.
    - flush -> IDLE in the same cycle, with no result.
  - DONE.
    - Apply sign fixes: lo = neg_q ? -q : q; hi = neg_r ? -rem : rem.
    - valid_o=1.
    - flush -> IDLE with valid_o forced 0 combinationally.
    - stall_ext=1 -> stay in DONE, holding valid_o and the result.
    - Otherwise -> IDLE next cycle.
- stall_o = (IDLE & start & !flush) | BUSY. It is 0 in DONE, so EX advances exactly in the DONE cycle when stall_ext=0.
- Latency: acceptance cycle T; BUSY during T+1..T+WIDTH; DONE (valid_o=1) at T+WIDTH+1. stall_o is high from T through T+WIDTH inclusive (WIDTH+1 cycles).
- Divide-by-zero latency: accept at T, DONE at T+1, stall_o high only at T.
- Overflow case: signed 0x80000000 / -1 gives lo=0x80000000, hi=0. This falls out naturally from magnitude arithmetic mod 2^WIDTH.
- Re-entry: a start in the cycle after DONE is a new instruction and is accepted normally. Back-to-back DIVs therefore cost WIDTH+2 cycles each.
- Operand changes: changes on opa/opb/signed_div during BUSY/DONE are ignored.
- Reset mid-operation: returns to IDLE next edge with all outputs at reset values.
- Simultaneous flush and rst: rst dominates.

Decomposition:
- Shared package (cpu_defs): DIV state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the WIDTH=32 constant.
- One sub-module is natural: div_step, a combinational single restoring iteration. Inputs: rem, q, divisor. Outputs: rem_next, q_next.
- The FSM, counter and sign logic stay in div_sequencer.

Test Plan:
- DIVU 100/7, start held, stall_ext=0:
  - stall_o high for 33 cycles; valid_o at T+33 with lo=14, hi=2; stall_o=0 that cycle.
- DIV -7/2:
  - lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV 0x80000000 / 0xFFFFFFFF:
  - lo=0x80000000, hi=0.
- DIVU 5/0:
  - DONE at T+1, lo=0xFFFFFFFF, hi=5, stall_o high one cycle only.
- flush at T+10 during BUSY:
  - IDLE next cycle, stall_o=0, valid_o never asserts.
  - A new start at T+12 (9/3) then completes with lo=3, hi=0.
- stall_ext=1 for 3 cycles while in DONE:
  - valid_o and the result held for 4 cycles; IDLE after stall_ext drops.
- rst asserted at T+5:
  - all outputs 0 next edge; no valid_o afterward.
